cp0_exc_ctrl: RTL and testbench

//  Coprocessor-0 exception/interrupt controller for the P7 pipeline. It takes the 5-bit exception code

---
 rtl/cp0_exc_ctrl_pkg.sv | 56 +++++
 rtl/cp0_exc_ctrl_if.sv | 27 ++
 rtl/cp0_int_arb.sv | 20 ++
 rtl/cp0_exc_ctrl.sv | 89 ++++++++
 tb/tb_cp0_exc_ctrl.sv | 220 ++++++++++++++++++++++
 5 files changed

// File: rtl/cp0_exc_ctrl_pkg.sv
// Shared CP0 definitions: exception codes, register indices and SR/Cause field layout.
// Also used by the exception-code stage so both sides agree on encodings.
package cp0_exc_ctrl_pkg;

    localparam logic [4:0] EXC_INT     = 5'd0;
    localparam logic [4:0] EXC_ADEL    = 5'd4;
    localparam logic [4:0] EXC_ADES    = 5'd5;
    localparam logic [4:0] EXC_SYSCALL = 5'd8;
    localparam logic [4:0] EXC_BREAK   = 5'd9;
    localparam logic [4:0] EXC_RI      = 5'd10;
    localparam logic [4:0] EXC_OV      = 5'd12;
    localparam logic [4:0] EXC_TRAP    = 5'd13;

    localparam logic [4:0] CP0_SR    = 5'd12;
    localparam logic [4:0] CP0_CAUSE = 5'd13;
    localparam logic [4:0] CP0_EPC   = 5'd14;
    localparam logic [4:0] CP0_PRID  = 5'd15;

    localparam int unsigned SR_IE_BIT     = 0;
    localparam int unsigned SR_EXL_BIT    = 1;
    localparam int unsigned SR_IM_LSB     = 10;
    localparam int unsigned CAUSE_EXC_LSB = 2;
    localparam int unsigned CAUSE_IP_LSB  = 10;
    localparam int unsigned CAUSE_BD_BIT  = 31;

    typedef struct packed {
        logic [5:0] im;
        logic       exl;
        logic       ie;
    } sr_t;

    typedef struct packed {
        logic       bd;
        logic [5:0] ip;
        logic [4:0] exc_code;
    } cause_t;

    function automatic logic [31:0] pack_sr(input sr_t s);
        logic [31:0] r;
        r = '0;
        r[SR_IM_LSB +: 6] = s.im;
        r[SR_EXL_BIT]     = s.exl;
        r[SR_IE_BIT]      = s.ie;
        return r;
    endfunction

    function automatic logic [31:0] pack_cause(input cause_t c);
        logic [31:0] r;
        r = '0;
        r[CAUSE_BD_BIT]          = c.bd;
        r[CAUSE_IP_LSB +: 6]     = c.ip;
        r[CAUSE_EXC_LSB +: 5]    = c.exc_code;
        return r;
    endfunction

endpackage

// File: rtl/cp0_exc_ctrl_if.sv
// Pipeline <-> CP0 signal bundle: mtc0/mfc0 access, commit-slot info and exception request.
interface cp0_exc_ctrl_if;

    logic        WE;
    logic [4:0]  CP0Addr;
    logic [31:0] CP0In;
    logic [31:0] VPC;
    logic        BDIn;
    logic [4:0]  ExcCodeIn;
    logic [5:0]  HWInt;
    logic        EXLClr;
    logic [31:0] CP0Out;
    logic [31:0] EPCOut;
    logic [31:0] HandlerPC;
    logic        Req;

    modport master (
        output WE, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        input  CP0Out, EPCOut, HandlerPC, Req
    );

    modport slave (
        input  WE, CP0Addr, CP0In, VPC, BDIn, ExcCodeIn, HWInt, EXLClr,
        output CP0Out, EPCOut, HandlerPC, Req
    );

endinterface

// File: rtl/cp0_int_arb.sv
// Decides whether an interrupt or exception is taken this cycle and which ExcCode to record.
module cp0_int_arb
    import cp0_exc_ctrl_pkg::*;
(
    input  logic [5:0] hw_int,
    input  sr_t        sr,
    input  logic [4:0] exc_code_in,
    output logic       int_req,
    output logic       exc_req,
    output logic       req,
    output logic [4:0] exc_code
);

    assign int_req  = (|(hw_int & sr.im)) & sr.ie & ~sr.exl;
    assign exc_req  = (exc_code_in != EXC_INT) & ~sr.exl;
    assign req      = int_req | exc_req;
    // Interrupts win over a simultaneous synchronous exception.
    assign exc_code = int_req ? EXC_INT : exc_code_in;

endmodule

// File: rtl/cp0_exc_ctrl.sv
// CP0 exception/interrupt controller: holds SR/Cause/EPC/PRId, raises Req and serves mfc0/mtc0/eret.
module cp0_exc_ctrl
    import cp0_exc_ctrl_pkg::*;
#(
    parameter logic [31:0] PRID    = 32'h5037_0007,
    parameter logic [31:0] HANDLER = 32'h0000_4180
) (
    input  logic            clk,
    input  logic            reset,
    cp0_exc_ctrl_if.slave   bus
);

    sr_t         sr_q, sr_d;
    cause_t      cause_q, cause_d;
    logic [29:0] epc_q, epc_d;

    logic       int_req;
    logic       exc_req;
    logic       arb_req;
    logic       req;
    logic [4:0] sel_code;

    cp0_int_arb u_int_arb (
        .hw_int      (bus.HWInt),
        .sr          (sr_q),
        .exc_code_in (bus.ExcCodeIn),
        .int_req     (int_req),
        .exc_req     (exc_req),
        .req         (arb_req),
        .exc_code    (sel_code)
    );

    assign req = arb_req & ~reset;

    // Priority per edge: exception entry, then eret, then mtc0.
    always_comb begin
        sr_d     = sr_q;
        cause_d  = cause_q;
        epc_d    = epc_q;
        cause_d.ip = bus.HWInt;
        if (req) begin
            sr_d.exl         = 1'b1;
            cause_d.bd       = bus.BDIn;
            cause_d.exc_code = sel_code;
            // Word-aligned EPC; the delay-slot case backs up one instruction, wrapping mod 2^32.
            epc_d = bus.BDIn ? bus.VPC[31:2] - 30'd1 : bus.VPC[31:2];
        end else begin
            if (bus.WE && bus.CP0Addr == CP0_SR) begin
                sr_d.im  = bus.CP0In[SR_IM_LSB +: 6];
                sr_d.exl = bus.CP0In[SR_EXL_BIT];
                sr_d.ie  = bus.CP0In[SR_IE_BIT];
            end
            if (bus.WE && bus.CP0Addr == CP0_EPC) begin
                epc_d = bus.CP0In[31:2];
            end
            if (bus.EXLClr) begin
                sr_d.exl = 1'b0;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sr_q    <= '0;
            cause_q <= '0;
            epc_q   <= '0;
        end else begin
            sr_q    <= sr_d;
            cause_q <= cause_d;
            epc_q   <= epc_d;
        end
    end

    always_comb begin
        bus.CP0Out = '0;
        case (bus.CP0Addr)
            CP0_SR:    bus.CP0Out = pack_sr(sr_q);
            CP0_CAUSE: bus.CP0Out = pack_cause(cause_q);
            CP0_EPC:   bus.CP0Out = {epc_q, 2'b00};
            CP0_PRID:  bus.CP0Out = PRID;
            default:   bus.CP0Out = '0;
        endcase
    end

    assign bus.EPCOut    = {epc_q, 2'b00};
    assign bus.HandlerPC = HANDLER;
    assign bus.Req       = req;

endmodule

// File: tb/tb_cp0_exc_ctrl.sv
// Self-checking bench for cp0_exc_ctrl: directed scenarios plus random traffic against a word-level model.
module tb_cp0_exc_ctrl;

    logic clk = 1'b0;
    logic reset;

    always #5 clk = ~clk;

    cp0_exc_ctrl_if bus ();

    cp0_exc_ctrl dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    // Reference state as full 32-bit architectural words.
    logic [31:0] m_sr;
    logic [31:0] m_cause;
    logic [31:0] m_epc;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%08h exp=%08h", tag, got, exp);
        end
    endtask

    function automatic logic model_int();
        return ((bus.HWInt & m_sr[15:10]) != 6'd0) && m_sr[0] && !m_sr[1];
    endfunction

    function automatic logic model_req();
        return model_int() || ((bus.ExcCodeIn != 5'd0) && !m_sr[1]);
    endfunction

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        case (a)
            5'd12:   return m_sr;
            5'd13:   return m_cause;
            5'd14:   return m_epc;
            5'd15:   return 32'h5037_0007;
            default: return 32'h0;
        endcase
    endfunction

    task automatic model_reset();
        m_sr = 32'h0; m_cause = 32'h0; m_epc = 32'h0;
    endtask

    task automatic model_step(input logic take, input logic is_int);
        logic [31:0] pc;
        if (take) begin
            m_sr[1]     = 1'b1;
            m_cause[31] = bus.BDIn;
            m_cause[6:2] = is_int ? 5'd0 : bus.ExcCodeIn;
            pc = bus.BDIn ? bus.VPC - 32'd4 : bus.VPC;
            m_epc = pc & ~32'd3;
        end else begin
            if (bus.WE && bus.CP0Addr == 5'd12) m_sr = bus.CP0In & 32'h0000_FC03;
            if (bus.WE && bus.CP0Addr == 5'd14) m_epc = bus.CP0In & ~32'd3;
            if (bus.EXLClr) m_sr[1] = 1'b0;
        end
        m_cause[15:10] = bus.HWInt;
    endtask

    task automatic drive(input logic we, input logic [4:0] addr, input logic [31:0] cin,
                         input logic [31:0] vpc, input logic bd, input logic [4:0] exc,
                         input logic [5:0] hw, input logic eret);
        bus.WE = we; bus.CP0Addr = addr; bus.CP0In = cin; bus.VPC = vpc;
        bus.BDIn = bd; bus.ExcCodeIn = exc; bus.HWInt = hw; bus.EXLClr = eret;
    endtask

    // Entered just after a rising edge; checks combinational outputs then advances one clock.
    task automatic cycle(input string tag);
        logic exp_req;
        logic exp_int;
        #2;
        exp_req = model_req();
        exp_int = model_int();
        check_eq({tag, ".req"}, {31'd0, bus.Req}, {31'd0, exp_req});
        check_eq({tag, ".rd"}, bus.CP0Out, model_rd(bus.CP0Addr));
        check_eq({tag, ".epcout"}, bus.EPCOut, m_epc);
        @(posedge clk);
        model_step(exp_req, exp_int);
        #1;
    endtask

    task automatic peek(input string tag, input logic [4:0] addr, input logic [31:0] exp);
        bus.CP0Addr = addr;
        #1;
        check_eq(tag, bus.CP0Out, exp);
    endtask

    task automatic eret_cycle();
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
        cycle("eret");
    endtask

    initial begin
        logic [4:0] addr;
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        reset = 1'b1;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check_eq("handler", bus.HandlerPC, 32'h0000_4180);

        // Asynchronous reset in the middle of a cycle.
        drive(1'b1, 5'd12, 32'h0000_FC01, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        cycle("t1.wr");
        peek("t1.sr_wr", 5'd12, 32'h0000_FC01);
        drive(1'b0, 5'd12, 32'h0, 32'h0000_3000, 1'b0, 5'd8, 6'd0, 1'b0);
        #1;
        reset = 1'b1;
        model_reset();
        #1;
        check_eq("t1.req", {31'd0, bus.Req}, 32'd0);
        peek("t1.sr", 5'd12, 32'h0);
        peek("t1.cause", 5'd13, 32'h0);
        peek("t1.epc", 5'd14, 32'h0);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // Plain exception, then no nesting while EXL is set.
        drive(1'b0, 5'd14, 32'h0, 32'h0000_3010, 1'b0, 5'd8, 6'd0, 1'b0);
        cycle("t2.exc");
        peek("t2.epc", 5'd14, 32'h0000_3010);
        peek("t2.cause", 5'd13, 32'h0000_0020);
        peek("t2.sr", 5'd12, 32'h0000_0002);
        drive(1'b0, 5'd13, 32'h0, 32'h0000_3040, 1'b0, 5'd9, 6'd0, 1'b0);
        #1;
        check_eq("t2.noreq", {31'd0, bus.Req}, 32'd0);
        cycle("t2.nest");

        // Exception in a branch delay slot.
        eret_cycle();
        drive(1'b0, 5'd0, 32'h0, 32'h0000_3024, 1'b1, 5'd13, 6'd0, 1'b0);
        cycle("t3.exc");
        peek("t3.epc", 5'd14, 32'h0000_3020);
        peek("t3.cause", 5'd13, 32'h8000_0034);

        // Interrupt beats exception; masked by IE=0.
        eret_cycle();
        drive(1'b1, 5'd12, 32'h0000_0401, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        cycle("t4.sr1");
        drive(1'b0, 5'd13, 32'h0, 32'h0000_3100, 1'b0, 5'd8, 6'b000001, 1'b0);
        #1;
        check_eq("t4.req", {31'd0, bus.Req}, 32'd1);
        cycle("t4.int");
        peek("t4.cause", 5'd13, 32'h0000_0400);
        peek("t4.sr", 5'd12, 32'h0000_0403);
        eret_cycle();
        drive(1'b1, 5'd12, 32'h0000_0400, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        cycle("t4.sr2");
        drive(1'b0, 5'd13, 32'h0, 32'h0, 1'b0, 5'd0, 6'b000001, 1'b0);
        #1;
        check_eq("t4.masked", {31'd0, bus.Req}, 32'd0);
        cycle("t4.ip");
        peek("t4.ip", 5'd13, 32'h0000_0400);

        // eret together with mtc0 EPC; then both dropped under Req.
        drive(1'b0, 5'd0, 32'h0, 32'h0000_3080, 1'b0, 5'd8, 6'd0, 1'b0);
        cycle("t5.exc");
        peek("t5.exl", 5'd12, 32'h0000_0402);
        drive(1'b1, 5'd14, 32'h0000_3100, 32'h0, 1'b0, 5'd0, 6'd0, 1'b1);
        cycle("t5.eret_wr");
        peek("t5.sr", 5'd12, 32'h0000_0400);
        peek("t5.epc", 5'd14, 32'h0000_3100);
        drive(1'b1, 5'd14, 32'h0000_5550, 32'h0000_3200, 1'b0, 5'd12, 6'd0, 1'b1);
        #1;
        check_eq("t5.req", {31'd0, bus.Req}, 32'd1);
        cycle("t5.drop");
        peek("t5.epc2", 5'd14, 32'h0000_3200);
        peek("t5.sr2", 5'd12, 32'h0000_0402);

        // VPC-4 wraps.
        eret_cycle();
        drive(1'b0, 5'd0, 32'h0, 32'h0, 1'b1, 5'd4, 6'd0, 1'b0);
        cycle("wrap.exc");
        peek("wrap.epc", 5'd14, 32'hFFFF_FFFC);

        // Read-only registers and unmapped addresses.
        eret_cycle();
        drive(1'b1, 5'd13, 32'hFFFF_FFFF, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        cycle("t6.wcause");
        drive(1'b1, 5'd15, 32'h0, 32'h0, 1'b0, 5'd0, 6'd0, 1'b0);
        cycle("t6.wprid");
        peek("t6.cause", 5'd13, 32'h8000_0010);
        peek("t6.prid", 5'd15, 32'h5037_0007);
        peek("t6.unmapped", 5'd7, 32'h0);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            case ($urandom_range(0, 5))
                0:       addr = 5'd12;
                1:       addr = 5'd13;
                2:       addr = 5'd14;
                3:       addr = 5'd15;
                default: addr = 5'($urandom_range(0, 31));
            endcase
            drive(($urandom_range(0, 2) == 0), addr, $urandom(), $urandom(),
                  1'($urandom_range(0, 1)),
                  ($urandom_range(0, 2) == 0) ? 5'($urandom_range(0, 31)) : 5'd0,
                  ($urandom_range(0, 3) == 0) ? 6'($urandom_range(0, 63)) : 6'd0,
                  ($urandom_range(0, 3) == 0));
            cycle("rnd");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
